// File: rtl/mu0_pkg.sv
// mu0_pkg: shared types, limits and op_len clamp for the MU0 phase sequencer
package mu0_pkg;

    localparam int MU0_MAX_EXEC_LIMIT = 8;
    localparam int LIMW = $clog2(MU0_MAX_EXEC_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } seq_state_e;

    // Saturate a requested phase count into 1..max
    function automatic logic [LIMW-1:0] clamp_len(input logic [LIMW-1:0] op, input logic [LIMW-1:0] max);
        return (op == '0) ? LIMW'(1) : (op > max) ? max : op;
    endfunction

endpackage

// File: rtl/mu0_phase_sequencer_if.sv
// mu0_phase_sequencer_if: decode/datapath bundle; perf counters exist only with MU0_SEQ_PERF_EN
interface mu0_phase_sequencer_if #(
    parameter int MAX_EXEC = 2,
    parameter int LENW = $clog2(MAX_EXEC + 1)
);
    logic                boot;
    logic [LENW-1:0]     op_len;
    logic                mem_ready;
    logic                halt_req;
    logic                fetch;
    logic [MAX_EXEC-1:0] exec;
    logic                halted;
    logic                instr_done;
    logic                busy;
`ifdef MU0_SEQ_PERF_EN
    logic [15:0]         retired_cnt;
    logic [15:0]         stall_cnt;

    modport master (
        output boot, op_len, mem_ready, halt_req,
        input  fetch, exec, halted, instr_done, busy, retired_cnt, stall_cnt
    );
    modport slave (
        input  boot, op_len, mem_ready, halt_req,
        output fetch, exec, halted, instr_done, busy, retired_cnt, stall_cnt
    );
`else
    modport master (
        output boot, op_len, mem_ready, halt_req,
        input  fetch, exec, halted, instr_done, busy
    );
    modport slave (
        input  boot, op_len, mem_ready, halt_req,
        output fetch, exec, halted, instr_done, busy
    );
`endif
endinterface

// File: rtl/mu0_len_clamp.sv
// mu0_len_clamp: combinational saturation of op_len into 1..MAX_EXEC
module mu0_len_clamp
    import mu0_pkg::*;
#(
    parameter int MAX_EXEC = 2,
    parameter int LENW = $clog2(MAX_EXEC + 1)
) (
    input  logic [LENW-1:0] op_len,
    output logic [LENW-1:0] len
);
    assign len = LENW'(clamp_len(LIMW'(op_len), LIMW'(MAX_EXEC)));
endmodule

// File: rtl/mu0_phase_sequencer.sv
// mu0_phase_sequencer: FETCH then 1..MAX_EXEC execute phases with stall, halt and retire pulse; MU0_SEQ_PERF_EN adds counters
module mu0_phase_sequencer
    import mu0_pkg::*;
#(
    parameter int MAX_EXEC = 2,
    parameter int LENW = $clog2(MAX_EXEC + 1)
) (
    input logic                   clk,
    input logic                   rst,
    mu0_phase_sequencer_if.slave  bus
);
    seq_state_e      state, nstate;
    logic [LENW-1:0] idx, nidx;
    logic [LENW-1:0] len_q, len_c, len_eff;
    logic            last, bad;

    mu0_len_clamp #(.MAX_EXEC(MAX_EXEC), .LENW(LENW)) u_clamp (
        .op_len (bus.op_len),
        .len    (len_c)
    );

    // EXEC1 sees the decoder's length directly; later phases use the latched copy
    assign len_eff = (idx == '0) ? len_c : len_q;
    assign bad     = (idx >= LENW'(MAX_EXEC)) || (idx >= len_eff);
    assign last    = (idx + LENW'(1)) == len_eff;

    // State, execute index and latched instruction length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            len_q <= LENW'(1);
        end else begin
            state <= nstate;
            idx   <= nidx;
            if (state == S_EXEC && idx == '0)
                len_q <= len_c;
        end
    end

    // Next state: boot low aborts, mem_ready low holds, otherwise advance
    always_comb begin
        nstate = state;
        nidx   = idx;
        if (!bus.boot) begin
            nstate = S_IDLE;
            nidx   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    nstate = S_FETCH;
                    nidx   = '0;
                end
                S_FETCH: if (bus.mem_ready) begin
                    nstate = S_EXEC;
                    nidx   = '0;
                end
                S_EXEC: begin
                    if (bad) begin
                        nstate = S_IDLE;
                        nidx   = '0;
                    end else if (bus.mem_ready) begin
                        nstate = last ? (bus.halt_req ? S_HALT : S_FETCH) : S_EXEC;
                        nidx   = last ? '0 : idx + LENW'(1);
                    end
                end
                S_HALT: nstate = S_HALT;
                default: begin
                    nstate = S_IDLE;
                    nidx   = '0;
                end
            endcase
        end
    end

    // Outputs decode from the registered state and live inputs
    always_comb begin
        bus.fetch      = state == S_FETCH;
        bus.exec       = (state == S_EXEC && !bad) ? MAX_EXEC'(1) << idx : '0;
        bus.halted     = state == S_HALT;
        bus.busy       = state == S_FETCH || state == S_EXEC;
        bus.instr_done = bus.boot && bus.mem_ready && state == S_EXEC && !bad && last;
    end

`ifdef MU0_SEQ_PERF_EN
    // Free-running retire and stall counters; only rst clears them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.retired_cnt <= '0;
            bus.stall_cnt   <= '0;
        end else begin
            if (bus.instr_done)
                bus.retired_cnt <= bus.retired_cnt + 16'd1;
            if (bus.busy && !bus.mem_ready)
                bus.stall_cnt <= bus.stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mu0_phase_sequencer.sv
// tb_mu0_phase_sequencer: scoreboarded directed vectors for the phase sequencer (MAX_EXEC=4)
module tb_mu0_phase_sequencer;

    localparam int MAXE = 4;

    typedef struct {
        logic        f;
        logic [3:0]  e;
        logic        h;
        logic        d;
        logic        b;
        logic        cc;
        logic [15:0] r;
        logic [15:0] s;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    mu0_phase_sequencer_if #(.MAX_EXEC(MAXE)) bus ();

    mu0_phase_sequencer #(.MAX_EXEC(MAXE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic b, input logic [2:0] op, input logic mr, input logic hr);
        bus.boot      = b;
        bus.op_len    = op;
        bus.mem_ready = mr;
        bus.halt_req  = hr;
    endtask

    task automatic push(input logic f, input logic [3:0] e, input logic h, input logic d, input logic bz,
                        input logic cc, input logic [15:0] r, input logic [15:0] s);
        exp_t x;
        x.f = f; x.e = e; x.h = h; x.d = d; x.b = bz; x.cc = cc; x.r = r; x.s = s;
        q.push_back(x);
    endtask

    task automatic step(input logic b, input logic [2:0] op, input logic mr, input logic hr,
                        input logic f, input logic [3:0] e, input logic h, input logic d, input logic bz,
                        input logic cc = 1'b0, input logic [15:0] r = 16'd0, input logic [15:0] s = 16'd0);
        @(posedge clk);
        #1;
        drive(b, op, mr, hr);
        push(f, e, h, d, bz, cc, r, s);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t x;
            x = q.pop_front();
            n_cmp++;
            if ({bus.fetch, bus.exec, bus.halted, bus.instr_done, bus.busy} != {x.f, x.e, x.h, x.d, x.b}) begin
                n_bad++;
                $display("FAIL outputs @%0t: got f=%b e=%b h=%b d=%b b=%b want f=%b e=%b h=%b d=%b b=%b",
                         $time, bus.fetch, bus.exec, bus.halted, bus.instr_done, bus.busy,
                         x.f, x.e, x.h, x.d, x.b);
            end
`ifdef MU0_SEQ_PERF_EN
            if (x.cc) begin
                n_cmp++;
                if (bus.retired_cnt != x.r || bus.stall_cnt != x.s) begin
                    n_bad++;
                    $display("FAIL counters @%0t: got retired=%0d stall=%0d want retired=%0d stall=%0d",
                             $time, bus.retired_cnt, bus.stall_cnt, x.r, x.s);
                end
            end
`endif
        end
    end

    initial begin
        drive(1'b0, 3'd2, 1'b1, 1'b0);
        step(0, 2, 1, 0, 0, 4'h0, 0, 0, 0);
        rst = 1'b0;
        step(1, 2, 1, 0, 0, 4'h0, 0, 0, 0);
        step(1, 2, 1, 0, 1, 4'h0, 0, 0, 1);
        step(1, 2, 1, 0, 0, 4'h1, 0, 0, 1);
        step(1, 2, 1, 0, 0, 4'h2, 0, 1, 1);
        step(1, 2, 1, 0, 1, 4'h0, 0, 0, 1);
        step(1, 2, 1, 0, 0, 4'h1, 0, 0, 1);
        step(1, 2, 1, 0, 0, 4'h2, 0, 1, 1);
        step(1, 1, 1, 0, 1, 4'h0, 0, 0, 1);
        step(1, 1, 1, 0, 0, 4'h1, 0, 1, 1);
        step(1, 3, 1, 0, 1, 4'h0, 0, 0, 1);
        step(1, 3, 1, 0, 0, 4'h1, 0, 0, 1);
        step(1, 0, 1, 0, 0, 4'h2, 0, 0, 1);
        step(1, 0, 1, 0, 0, 4'h4, 0, 1, 1);
        step(1, 0, 1, 0, 1, 4'h0, 0, 0, 1);
        step(1, 0, 1, 0, 0, 4'h1, 0, 1, 1);
        step(1, 7, 1, 0, 1, 4'h0, 0, 0, 1);
        step(1, 7, 1, 0, 0, 4'h1, 0, 0, 1);
        step(1, 7, 1, 0, 0, 4'h2, 0, 0, 1);
        step(1, 7, 1, 0, 0, 4'h4, 0, 0, 1);
        step(1, 7, 1, 0, 0, 4'h8, 0, 1, 1);
        step(1, 2, 1, 0, 1, 4'h0, 0, 0, 1);
        step(1, 2, 1, 0, 0, 4'h1, 0, 0, 1);
        step(1, 2, 0, 0, 0, 4'h2, 0, 0, 1);
        step(1, 2, 0, 0, 0, 4'h2, 0, 0, 1);
        step(1, 2, 0, 0, 0, 4'h2, 0, 0, 1);
        step(1, 2, 1, 0, 0, 4'h2, 0, 1, 1);
        step(1, 1, 1, 1, 1, 4'h0, 0, 0, 1, 1, 16'd7, 16'd3);
        step(1, 1, 1, 1, 0, 4'h1, 0, 1, 1);
        step(1, 1, 1, 0, 0, 4'h0, 1, 0, 0);
        step(1, 1, 0, 1, 0, 4'h0, 1, 0, 0);
        step(0, 1, 1, 0, 0, 4'h0, 1, 0, 0);
        step(1, 1, 1, 0, 0, 4'h0, 0, 0, 0);
        step(1, 1, 1, 0, 1, 4'h0, 0, 0, 1);
        step(0, 1, 1, 0, 0, 4'h1, 0, 0, 1);
        step(1, 2, 1, 0, 0, 4'h0, 0, 0, 0);
        step(1, 2, 1, 0, 1, 4'h0, 0, 0, 1);
        step(1, 2, 1, 0, 0, 4'h1, 0, 0, 1);
        @(posedge clk);
        #1;
        drive(1'b1, 3'd2, 1'b0, 1'b0);
        push(0, 4'h0, 0, 0, 0, 1'b0, 16'd0, 16'd0);
        #2;
        rst = 1'b1;
        step(0, 2, 1, 0, 0, 4'h0, 0, 0, 0);
        rst = 1'b0;
        step(1, 2, 1, 0, 0, 4'h0, 0, 0, 0, 1, 16'd0, 16'd0);
        step(1, 2, 1, 0, 1, 4'h0, 0, 0, 1);
        for (int i = 0; i < 10 && q.size() != 0; i++)
            @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mu0_phase_sequencer.md
Name: mu0_phase_sequencer

Overview:
- Parametrised successor to the fixed fetch/exec1/exec2 CPU state decoder.
- Registered sequencer driving the MU0-family datapath through one FETCH phase, then 1..MAX_EXEC execute phases per instruction.
- Instruction length comes from the decoder; adds a memory-ready stall handshake, a halt state and an instruction-retired pulse.
- Sits between instruction decode and datapath/memory control in the CPU top level.

Parameters:
- MAX_EXEC, 2, maximum execute phases per instruction (legal 1..8).
- LENW, $clog2(MAX_EXEC+1), width of the op_len input.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- boot  in  1  run enable; low forces IDLE.
- op_len  in  LENW  execute phases the current instruction needs; valid during EXEC1.
- mem_ready  in  1  memory/datapath ready; low stalls the current phase.
- halt_req  in  1  stop after the current instruction retires.
- fetch  out  1  high in FETCH.
- exec  out  MAX_EXEC  one-hot; bit k high in execute phase k+1.
- halted  out  1  high in HALT.
- instr_done  out  1  one-cycle pulse on the final execute cycle that completes.
- busy  out  1  high in FETCH or any EXEC state.

Behaviour:
- Reset: state=IDLE, len_q=1. Outputs at reset: fetch=0, exec=0, halted=0, instr_done=0, busy=0.
- All outputs decode combinationally from the registered state and current inputs. There is no output latency beyond the state register.
- States: IDLE, FETCH, EXEC1..EXEC<MAX_EXEC>, HALT.
- Transition priority, highest first: boot low, then mem_ready low, then normal sequencing.
- boot=0: next state is IDLE from any state, including mid-instruction. instr_done=0 that cycle.
- IDLE: boot=1 -> FETCH.
- FETCH: mem_ready=1 -> EXEC1; otherwise hold FETCH.
- EXEC1:
  - len_q <= op_len, clamped: 0 becomes 1, and anything above MAX_EXEC becomes MAX_EXEC.
  - The effective length used in EXEC1 is the clamped op_len itself, not len_q.
- EXECk, k<len: mem_ready=1 -> EXEC(k+1); otherwise hold. A held state keeps its output asserted.
- EXECk, k==len:
  - mem_ready=1: instr_done=1; next is HALT if halt_req=1, else FETCH.
  - mem_ready=0: hold, instr_done=0.
- halt_req is sampled only on the completing cycle. Assertions at any other time are ignored.
- HALT: held while boot=1. boot=0 -> IDLE. boot must then rise again to restart at FETCH.
- len_q is held across stalls. A stalled EXEC1 keeps reloading len_q from op_len, so the decoder must hold op_len stable while stalled.
- With MAX_EXEC=2 and op_len=2, the state sequence equals the legacy fetch/exec1/exec2 cycle.
- Illegal or unreachable state encodings recover to IDLE on the next clock.
- instr_done never asserts in IDLE, FETCH or HALT.

Optional Feature:
- Macro MU0_SEQ_PERF_EN.
- Defined: adds outputs retired_cnt (16-bit) and stall_cnt (16-bit).
  - retired_cnt increments on instr_done.
  - stall_cnt increments on every busy && !mem_ready cycle.
  - Both wrap at 0xFFFF -> 0 and clear on rst.
  - boot does not clear either counter.
- Not defined: neither port nor the counter logic exists. Sequencing is identical in both builds.

Decomposition:
- Package mu0_pkg holds:
  - state typedef seq_state_e (IDLE, FETCH, EXEC, HALT class), with the execute index as a separate counter field;
  - constant MU0_MAX_EXEC_LIMIT=8;
  - the clamp function for op_len.
- The state register plus the exec index counter (width LENW) lives in the top module.
- One natural sub-module, mu0_len_clamp (combinational op_len saturation), reusable by the decoder.

Test Plan:
- Legacy sequence: MAX_EXEC=2, boot=1, mem_ready=1, op_len=2, from reset. Expect fetch,exec[0],exec[1] repeating; instr_done on every 3rd cycle; busy=1 throughout.
- Variable length: op_len=1 then 3 on consecutive instructions (MAX_EXEC=4). Expect F,E1,done / F,E1,E2,E3,done, with instr_done on E1 and E3 respectively.
- Clamp: op_len=0 gives a 1-phase instruction. op_len=7 with MAX_EXEC=4 gives 4 phases.
- Stall: mem_ready=0 for 3 cycles during E2 of a 2-phase instruction. Expect exec[1] held for 4 cycles; instr_done only on the 4th; stall_cnt=3 when PERF is enabled.
- Halt: halt_req=1 on the completing cycle. Expect HALT next cycle (halted=1, busy=0) and held while boot=1. boot=0 then 1 gives IDLE, then FETCH.
- Abort: boot=0 during E1, plus async rst pulse mid-E2. Expect IDLE next cycle with instr_done=0; rst clears all outputs immediately, without waiting for a clock edge.
